// File: rtl/spi_slave_shifter.sv
// SPI mode-0 slave shift engine: MSB-first, full duplex, driven by pre-synchronized
// SCLK/CS strobes in the system clock domain, with a single-word transmit holding register.
module spi_slave_shifter #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cs_n_i,
  input  logic                  cs_fall_i,
  input  logic                  sclk_pe_i,
  input  logic                  sclk_ne_i,
  input  logic                  mosi_i,
  output logic                  miso_o,
  output logic                  miso_oe_o,
  input  logic [DATA_WIDTH-1:0] tx_data_i,
  input  logic                  tx_valid_i,
  output logic                  tx_ready_o,
  output logic [DATA_WIDTH-1:0] rx_data_o,
  output logic                  rx_valid_o,
  output logic                  busy_o,
  output logic                  tx_underrun_o,
  output logic                  frame_abort_o
);

  localparam int CNT_W = $clog2(DATA_WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] tx_hold_q, tx_hold_d;
  logic                  hold_full_q, hold_full_d;
  logic [DATA_WIDTH-1:0] tx_shreg_q, tx_shreg_d;
  logic [DATA_WIDTH-1:0] rx_shreg_q, rx_shreg_d;
  logic [DATA_WIDTH-1:0] rx_data_q, rx_data_d;
  logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
  logic                  load_pend_q, load_pend_d;
  logic                  rx_valid_q, rx_valid_d;
  logic                  underrun_q, underrun_d;
  logic                  abort_q, abort_d;
  logic                  word_load;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      tx_hold_q   <= '0;
      hold_full_q <= 1'b0;
      tx_shreg_q  <= '0;
      rx_shreg_q  <= '0;
      rx_data_q   <= '0;
      bit_cnt_q   <= '0;
      load_pend_q <= 1'b0;
      rx_valid_q  <= 1'b0;
      underrun_q  <= 1'b0;
      abort_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      tx_hold_q   <= tx_hold_d;
      hold_full_q <= hold_full_d;
      tx_shreg_q  <= tx_shreg_d;
      rx_shreg_q  <= rx_shreg_d;
      rx_data_q   <= rx_data_d;
      bit_cnt_q   <= bit_cnt_d;
      load_pend_q <= load_pend_d;
      rx_valid_q  <= rx_valid_d;
      underrun_q  <= underrun_d;
      abort_q     <= abort_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    tx_hold_d   = tx_hold_q;
    hold_full_d = hold_full_q;
    tx_shreg_d  = tx_shreg_q;
    rx_shreg_d  = rx_shreg_q;
    rx_data_d   = rx_data_q;
    bit_cnt_d   = bit_cnt_q;
    load_pend_d = load_pend_q;
    rx_valid_d  = 1'b0;
    underrun_d  = 1'b0;
    abort_d     = 1'b0;
    word_load   = 1'b0;

    case (state_q)
      IDLE: begin
        bit_cnt_d = '0;
        if (cs_fall_i) begin
          word_load   = 1'b1;
          load_pend_d = 1'b0;
          state_d     = SHIFT;
        end
      end
      SHIFT: begin
        // CS release wins over any SCLK strobe arriving in the same cycle
        if (cs_n_i) begin
          state_d     = IDLE;
          bit_cnt_d   = '0;
          load_pend_d = 1'b0;
          rx_shreg_d  = '0;
          abort_d     = (bit_cnt_q != '0);
        end else if (sclk_pe_i) begin
          rx_shreg_d = {rx_shreg_q[DATA_WIDTH-2:0], mosi_i};
          if (bit_cnt_q == LAST_BIT) begin
            rx_data_d   = {rx_shreg_q[DATA_WIDTH-2:0], mosi_i};
            rx_valid_d  = 1'b1;
            bit_cnt_d   = '0;
            load_pend_d = 1'b1;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end else if (sclk_ne_i) begin
          if (load_pend_q) begin
            word_load   = 1'b1;
            load_pend_d = 1'b0;
          end else begin
            tx_shreg_d = {tx_shreg_q[DATA_WIDTH-2:0], 1'b0};
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (word_load) begin
      if (hold_full_q) begin
        tx_shreg_d  = tx_hold_q;
        hold_full_d = 1'b0;
      end else begin
        tx_shreg_d = '0;
        underrun_d = 1'b1;
      end
    end

    // A handshake is only possible with the holding register empty, so it always lands after the load
    if (tx_valid_i && !hold_full_q) begin
      tx_hold_d   = tx_data_i;
      hold_full_d = 1'b1;
    end
  end

  assign miso_o        = tx_shreg_q[DATA_WIDTH-1];
  assign miso_oe_o     = (state_q == SHIFT);
  assign busy_o        = (state_q == SHIFT);
  assign tx_ready_o    = ~hold_full_q;
  assign rx_data_o     = rx_data_q;
  assign rx_valid_o    = rx_valid_q;
  assign tx_underrun_o = underrun_q;
  assign frame_abort_o = abort_q;

endmodule

// File: doc/spi_slave_shifter.md
# spi_slave_shifter

SPI mode-0 slave shift engine: MSB-first, full-duplex, configurable word width. It consumes the already-synchronized SCLK edge strobes, the chip-select level and edge, and the MOSI level produced by the input synchronizer stage. It exchanges parallel words with the core through a transmit holding-register handshake and a receive valid pulse. All logic runs in the system clock domain; SCLK is never used as a clock.

## Interface
- DATA_WIDTH, 8, bits per SPI word; legal range 2..32.
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- cs_n_i  in  1  synchronized chip select, active low.
- cs_fall_i  in  1  one-cycle strobe: cs_n_i went 1→0.
- sclk_pe_i  in  1  one-cycle strobe: SCLK rising edge.
- sclk_ne_i  in  1  one-cycle strobe: SCLK falling edge. Never high in the same cycle as sclk_pe_i.
- mosi_i  in  1  synchronized MOSI level.
- miso_o  out  1  serial transmit bit; always equals tx_shreg[DATA_WIDTH-1].
- miso_oe_o  out  1  MISO pad output enable; high exactly while in state SHIFT.
- tx_data_i  in  DATA_WIDTH  word to transmit.
- tx_valid_i  in  1  tx_data_i is valid.
- tx_ready_o  out  1  holding register empty. A transfer occurs on tx_valid_i & tx_ready_o.
- rx_data_o  out  DATA_WIDTH  last completely received word.
- rx_valid_o  out  1  one-cycle pulse: rx_data_o was updated.
- busy_o  out  1  frame in progress (state SHIFT).
- tx_underrun_o  out  1  one-cycle pulse: a word load found the holding register empty.
- frame_abort_o  out  1  one-cycle pulse: CS deasserted with bit_cnt ≠ 0.

## Operation
Internal state:
- tx_hold and hold_full. tx_ready_o is the registered value of ~hold_full.
- tx_shreg and rx_shreg, each DATA_WIDTH bits.
- bit_cnt, $clog2(DATA_WIDTH) bits.
- load_pend flag.

Word load:
- tx_shreg ← tx_hold and hold_full ← 0 if hold_full.
- Otherwise tx_shreg ← 0 and tx_underrun_o pulses.
- A tx handshake in the same cycle as a load writes tx_hold after the load. The new word serves the next load, and hold_full ends at 1.

States:
- IDLE: miso_oe_o = 0, bit_cnt = 0.
  - On cs_fall_i: do a word load, clear load_pend, go to SHIFT.
  - SCLK strobes are ignored in IDLE.
- SHIFT: miso_oe_o = 1.
  - On sclk_pe_i: rx_shreg ← {rx_shreg[DATA_WIDTH-2:0], mosi_i}.
  - If bit_cnt = DATA_WIDTH-1 on that sclk_pe_i: rx_data_o ← {rx_shreg[DATA_WIDTH-2:0], mosi_i}, rx_valid_o pulses, bit_cnt ← 0 (wrap), load_pend ← 1.
  - Otherwise on that sclk_pe_i: bit_cnt ← bit_cnt + 1.
  - On sclk_ne_i: if load_pend, do a word load and clear load_pend; else tx_shreg ← {tx_shreg[DATA_WIDTH-2:0], 1'b0}.
  - On cs_n_i = 1: go to IDLE. Clear bit_cnt and load_pend. Pulse frame_abort_o if bit_cnt ≠ 0. The partial rx word is discarded, with no rx_valid_o. tx_shreg keeps its value. An unconsumed tx_hold stays full.
  - CS deassertion takes priority over an SCLK strobe in the same cycle.
- Back-to-back frames: a cs_fall_i in the cycle after returning to IDLE is honoured normally.

Reset values (while rst_n = 0): state IDLE; miso_o 0, miso_oe_o 0, tx_ready_o 1, rx_data_o 0, rx_valid_o 0, busy_o 0, tx_underrun_o 0, frame_abort_o 0; all shift registers, bit_cnt, load_pend and hold_full cleared. Reset asserted mid-frame aborts immediately without any pulse.

## Timing
- All outputs are registered and change one clk after the qualifying input cycle.
- First MISO bit: valid the cycle after cs_fall_i, before the first SCLK rising edge, as mode 0 requires.
- rx_valid_o: high for exactly one cycle, beginning the cycle after the sclk_pe_i that sampled the last bit (bit DATA_WIDTH-1).
- miso_o: changes the cycle after each sclk_ne_i. The next word's MSB appears after the falling edge that follows the word's last rising edge.
- tx_ready_o: falls the cycle after a handshake. It rises the cycle after the load that empties tx_hold.
- Minimum SCLK half-period: 2 clk, plus synchronizer latency.

## Test plan
- Single frame, DATA_WIDTH = 8: preload tx 0xA5, master sends 0x3C → miso bits 1,0,1,0,0,1,0,1; rx_data_o = 0x3C; exactly one rx_valid_o; frame_abort_o stays 0.
- Two words in one frame: preload 0x81, write 0x7E during the first word → second word on MISO is 0x7E, rx_valid_o pulses twice, no underrun.
- Underrun: no tx data before cs_fall_i → tx_underrun_o pulses once, MISO transmits 0x00, reception still correct.
- Abort: CS deasserted after 3 rising edges → frame_abort_o pulses, no rx_valid_o; the next frame receives 0x55 correctly from bit 0.
- Async reset mid-frame (rst_n low for a non-clock-aligned interval) → all outputs at reset values immediately, tx_ready_o = 1.
- SCLK strobes with cs_n_i = 1 → no state change; miso_oe_o = 0; rx_valid_o stays 0.
